// File: rtl/axi_interface_master_write_pkg.sv
// rtl/axi_interface_master_write_pkg.sv - widths, request struct and helpers for the AXI write master
// Same guard as define.sv, so whichever of the two is compiled first supplies the macros.
`ifndef AXI_DEFINE_SV
`define AXI_DEFINE_SV
`define ID_BITS     4
`define ADDR_WIDTH  32
`define LEN_BITS    8
`define SIZE_BITS   3
`define DATA_WIDTH  32
`define RESP_OKAY   3'b000
`define BURST_FIXED 2'b00
`define BURST_INCR  2'b01
`define BURST_WRAP  2'b10
`endif

package axi_interface_master_write_pkg;

    localparam int ID_W   = `ID_BITS;
    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int LEN_W  = `LEN_BITS;
    localparam int SIZE_W = `SIZE_BITS;
    localparam int DATA_W = `DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [2:0] RESP_OKAY   = `RESP_OKAY;
    localparam logic [1:0] BURST_FIXED = `BURST_FIXED;
    localparam logic [1:0] BURST_INCR  = `BURST_INCR;
    localparam logic [1:0] BURST_WRAP  = `BURST_WRAP;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        logic [1:0]        burst;
    } aw_req_t;

    function automatic logic resp_is_err(input logic [2:0] resp,
                                         input logic [ID_W-1:0] bid,
                                         input logic [ID_W-1:0] id);
        return (resp != RESP_OKAY) || (bid != id);
    endfunction

endpackage

// File: rtl/axi_interface_master_write_fifo.sv
// rtl/axi_interface_master_write_fifo.sv - first-word fall-through FIFO holding {wstrb, wdata} beats
module axi_wdata_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is flushed by the pointer reset; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/define.sv
// rtl/define.sv - shared AXI widths, response and burst encodings
`ifndef AXI_DEFINE_SV
`define AXI_DEFINE_SV
`define ID_BITS     4
`define ADDR_WIDTH  32
`define LEN_BITS    8
`define SIZE_BITS   3
`define DATA_WIDTH  32
`define RESP_OKAY   3'b000
`define BURST_FIXED 2'b00
`define BURST_INCR  2'b01
`define BURST_WRAP  2'b10
`endif

// File: rtl/axi_interface_master_write.sv
// rtl/axi_interface_master_write.sv - single-outstanding AXI write master with buffered write data
module axi_interface_master_write
    import axi_interface_master_write_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [SIZE_W-1:0] i_size,
    input  logic [1:0]        i_burst,
    input  logic [ID_W-1:0]   i_id,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_bresp,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [SIZE_W-1:0] awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [ID_W-1:0]   bid,
    input  logic [2:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                     state;
    aw_req_t                    req_q;
    logic [LEN_W-1:0]           beat_cnt;
    logic [STRB_W+DATA_W-1:0]   fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       w_hs;

    axi_wdata_fifo #(
        .WIDTH (STRB_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (i_wvalid),
        .push_data ({i_wstrb, i_wdata}),
        .pop       (w_hs),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Every output comes from state registers or the FIFO head, never from awready/wready/bvalid.
    assign o_req_ready = (state == S_IDLE);
    assign o_wready    = !fifo_full;
    assign awvalid     = (state == S_ADDR);
    assign bready      = (state == S_RESP);
    assign wvalid      = (state == S_DATA) && !fifo_empty;
    assign wlast       = (state == S_DATA) && (beat_cnt == req_q.len);
    assign wdata       = wvalid ? fifo_head[DATA_W-1:0] : '0;
    assign wstrb       = wvalid ? fifo_head[STRB_W+DATA_W-1:DATA_W] : '0;
    assign w_hs        = wvalid && wready;

    assign awid    = req_q.id;
    assign awaddr  = req_q.addr;
    assign awlen   = req_q.len;
    assign awsize  = req_q.size;
    assign awburst = req_q.burst;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            req_q    <= '0;
            beat_cnt <= '0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_bresp  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        req_q    <= '{id: i_id, addr: i_addr, len: i_len,
                                      size: i_size, burst: i_burst};
                        beat_cnt <= '0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (awready) state <= S_DATA;
                end
                S_DATA: begin
                    if (w_hs) begin
                        if (beat_cnt == req_q.len) state <= S_RESP;
                        else                       beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bvalid) begin
                        o_bresp <= bresp;
                        o_err   <= resp_is_err(bresp, bid, req_q.id);
                        o_done  <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_interface_master_write.sv
// tb/tb_axi_interface_master_write.sv - self-checking bench for axi_interface_master_write
module tb_axi_interface_master_write;
    import axi_interface_master_write_pkg::*;

    localparam int DEPTH = 8;

    logic              clk_i;
    logic              rst_i;
    logic              i_req;
    logic              o_req_ready;
    logic [ADDR_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic [SIZE_W-1:0] i_size;
    logic [1:0]        i_burst;
    logic [ID_W-1:0]   i_id;
    logic [DATA_W-1:0] i_wdata;
    logic [STRB_W-1:0] i_wstrb;
    logic              i_wvalid;
    logic              o_wready;
    logic              o_done;
    logic              o_err;
    logic [2:0]        o_bresp;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [SIZE_W-1:0] awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [2:0]        bresp;
    logic              bvalid;
    logic              bready;

    int n_cmp = 0;
    int n_err = 0;
    logic [35:0] q[$];

    axi_interface_master_write #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req(i_req), .o_req_ready(o_req_ready),
        .i_addr(i_addr), .i_len(i_len), .i_size(i_size), .i_burst(i_burst), .i_id(i_id),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_done(o_done), .o_err(o_err), .o_bresp(o_bresp),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [3:0] s);
        check("o_wready_idle", o_wready, q.size() < DEPTH);
        i_wvalid = 1'b1; i_wdata = d; i_wstrb = s;
        @(posedge clk_i); #1;
        if (q.size() < DEPTH) q.push_back({s, d});
        i_wvalid = 1'b0;
    endtask

    // One whole burst: the model tracks FIFO contents, beats sent and channel phases.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input logic [1:0] burst, input logic [2:0] size,
                             input logic [2:0] resp, input logic [3:0] bid_v,
                             input int maxstall, input int push_delay, input int npush,
                             input int abort_beats);
        int beats = 0, cyc = 0, since_aw = 0, pushed = 0, aw_stall, w_stall;
        bit aw_done = 0, b_done = 0, aborted = 0, aw_hs, w_hs, b_hs, push_acc, w_stalled = 0;
        logic [31:0] prev_wdata = '0;
        logic        prev_wlast = 1'b0;
        logic [35:0] pdat = '0;
        logic        err_exp;
        err_exp = (resp != RESP_OKAY) || (bid_v != id);

        check("req_ready_idle", o_req_ready, 1'b1);
        i_req = 1'b1; i_addr = addr; i_len = len; i_id = id; i_burst = burst; i_size = size;
        @(posedge clk_i); #1;
        i_req = 1'b0; i_addr = $urandom; i_len = 8'($urandom); i_id = 4'($urandom);
        check("awvalid_after_accept", awvalid, 1'b1);
        aw_stall = $urandom_range(0, maxstall);
        w_stall  = $urandom_range(0, maxstall);

        while (!b_done && !aborted && cyc < 300) begin
            check("awvalid", awvalid, !aw_done);
            check("req_ready_busy", o_req_ready, 1'b0);
            check("o_done_quiet", o_done, 1'b0);
            check("wvalid", wvalid, aw_done && beats <= len && q.size() != 0);
            check("bready", bready, aw_done && beats == len + 1);
            check("o_wready", o_wready, q.size() < DEPTH);
            if (w_stalled) begin
                check("wdata_stable", wdata, prev_wdata);
                check("wlast_stable", wlast, prev_wlast);
            end
            if (awvalid) begin
                check("awaddr", awaddr, addr);
                check("awlen", awlen, len);
                check("awid", awid, id);
                check("awburst", awburst, burst);
                check("awsize", awsize, size);
            end
            if (wvalid && q.size() != 0) begin
                check("wdata", wdata, q[0][31:0]);
                check("wstrb", wstrb, q[0][35:32]);
                check("wlast", wlast, beats == len);
            end

            aw_hs = 0;
            if (awvalid) begin
                if (aw_stall > 0) begin awready = 1'b0; aw_stall--; end
                else begin awready = 1'b1; aw_hs = 1; end
            end else awready = 1'($urandom_range(0, 1));

            w_hs = 0;
            if (wvalid) begin
                if (w_stall > 0) begin wready = 1'b0; w_stall--; end
                else begin wready = 1'b1; w_hs = 1; w_stall = $urandom_range(0, maxstall); end
            end else wready = 1'($urandom_range(0, 1));
            w_stalled  = wvalid && !wready;
            prev_wdata = wdata;
            prev_wlast = wlast;

            push_acc = 0; i_wvalid = 1'b0;
            if (push_delay >= 0 && aw_done && since_aw >= push_delay && pushed < npush && q.size() < DEPTH) begin
                pdat = {4'($urandom), 32'($urandom)};
                i_wvalid = 1'b1; i_wdata = pdat[31:0]; i_wstrb = pdat[35:32];
                push_acc = 1;
            end

            b_hs = 0;
            if (aw_done && beats == len + 1) begin
                bvalid = 1'b1; bid = bid_v; bresp = resp; b_hs = 1;
            end else begin
                bvalid = 1'($urandom_range(0, 1)); bid = 4'($urandom); bresp = 3'($urandom);
            end

            @(posedge clk_i); #1;
            if (w_hs) begin
                if (q.size() != 0) void'(q.pop_front());
                beats++;
            end
            if (push_acc) begin q.push_back(pdat); pushed++; end
            if (aw_done) since_aw++;
            if (aw_hs) aw_done = 1;
            if (b_hs) begin
                check("o_done", o_done, 1'b1);
                check("o_err", o_err, err_exp);
                check("o_bresp", o_bresp, resp);
                b_done = 1;
            end
            if (abort_beats >= 0 && beats == abort_beats) aborted = 1;
            cyc++;
        end

        i_wvalid = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        if (!aborted) begin
            check("burst_completed", b_done, 1'b1);
            @(posedge clk_i); #1;
            check("o_done_one_cycle", o_done, 1'b0);
            check("req_ready_after", o_req_ready, 1'b1);
        end
    endtask

    initial begin
        int p, len;
        rst_i = 1'b1; i_req = 1'b0; i_addr = '0; i_len = '0; i_size = '0; i_burst = '0; i_id = '0;
        i_wdata = '0; i_wstrb = '0; i_wvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_o_done", o_done, 1'b0);
        check("rst_req_ready", o_req_ready, 1'b1);
        check("rst_o_wready", o_wready, 1'b1);
        check("rst_awaddr", awaddr, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Preloaded four-beat INCR burst, slave always ready
        push_beat(32'h11, 4'hF); push_beat(32'h22, 4'hF);
        push_beat(32'h33, 4'hF); push_beat(32'h44, 4'hF);
        run_burst(32'h100, 8'd3, 4'd2, BURST_INCR, 3'd2, RESP_OKAY, 4'd2, 0, -1, 0, -1);

        // Single beat, data arrives after the address phase
        run_burst(32'h200, 8'd0, 4'd1, BURST_INCR, 3'd2, RESP_OKAY, 4'd1, 0, 3, 1, -1);

        // Fill past capacity, then drain with a full-depth burst
        for (int i = 0; i < 9; i++) push_beat($urandom, 4'($urandom));
        check("o_wready_full", o_wready, 1'b0);
        run_burst(32'h300, 8'd7, 4'd3, BURST_WRAP, 3'd2, RESP_OKAY, 4'd3, 1, -1, 0, -1);

        // Random lengths, preload split and slave stalls
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(0, 7);
            p = $urandom_range(0, len + 1);
            for (int i = 0; i < p; i++) push_beat($urandom, 4'($urandom));
            run_burst($urandom, 8'(len), 4'($urandom), 2'($urandom_range(0, 2)), 3'($urandom_range(0, 2)),
                      RESP_OKAY, 4'(0), 3, $urandom_range(0, 3), len + 1 - p, -1);
        end

        // Error responses: foreign bid, then SLVERR
        push_beat(32'hA5A5_0001, 4'h3);
        run_burst(32'h400, 8'd0, 4'd2, BURST_INCR, 3'd2, RESP_OKAY, 4'd5, 1, -1, 0, -1);
        push_beat(32'hA5A5_0002, 4'hC);
        run_burst(32'h404, 8'd0, 4'd2, BURST_FIXED, 3'd2, 3'd2, 4'd2, 1, -1, 0, -1);

        // Reset in the middle of the data phase
        for (int i = 0; i < 4; i++) push_beat($urandom, 4'hF);
        run_burst(32'h500, 8'd3, 4'd6, BURST_INCR, 3'd2, RESP_OKAY, 4'd6, 0, -1, 0, 2);
        rst_i = 1'b1;
        #1;
        check("midrst_awvalid", awvalid, 1'b0);
        check("midrst_wvalid", wvalid, 1'b0);
        check("midrst_wlast", wlast, 1'b0);
        check("midrst_bready", bready, 1'b0);
        check("midrst_o_err", o_err, 1'b0);
        check("midrst_o_bresp", o_bresp, 0);
        check("midrst_req_ready", o_req_ready, 1'b1);
        check("midrst_o_wready", o_wready, 1'b1);
        check("midrst_awaddr", awaddr, 0);
        check("midrst_wdata", wdata, 0);
        q.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        run_burst(32'h600, 8'd1, 4'd7, BURST_INCR, 3'd2, RESP_OKAY, 4'd7, 2, 0, 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
